// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op encoding, FSM state
// type and helpers that classify ops.
package md_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MADD  = 3'd4,
    MD_MADDU = 3'd5,
    MD_MTHI  = 3'd6,
    MD_MTLO  = 3'd7
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  localparam int CNT_W = 6;

  function automatic logic is_multi_cycle(input md_op_e op);
    return op <= MD_MADDU;
  endfunction

  function automatic logic is_div(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_if.sv
// EX-stage request/response bundle between the pipeline and the MD unit.
interface md_if #(parameter int WIDTH = 32);
  import md_pkg::*;

  logic             start;
  md_op_e           md_op;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic             md_type;
  logic             busy;
  logic             stall_req;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, md_op, rs_data, rt_data, md_type,
    input  busy, stall_req, hi, lo
  );

  modport slave (
    input  start, md_op, rs_data, rt_data, md_type,
    output busy, stall_req, hi, lo
  );

endinterface

// File: rtl/md_calc.sv
// Combinational multiply/divide datapath producing the full {hi,lo} result
// for the latched op, including divide-by-zero and signed-overflow cases.
module md_calc import md_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  md_op_e             op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   hi,
  input  logic [WIDTH-1:0]   lo,
  output logic [2*WIDTH-1:0] result
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  logic signed [2*WIDTH-1:0] s_prod;
  logic [2*WIDTH-1:0]        u_prod;
  logic                      div_zero;
  logic                      div_ovf;
  logic [WIDTH-1:0]          divisor;
  logic [WIDTH-1:0]          s_quot;
  logic [WIDTH-1:0]          s_rem;
  logic [WIDTH-1:0]          u_quot;
  logic [WIDTH-1:0]          u_rem;

  // The divider never sees zero or MOST_NEG/-1; those cases are patched below.
  always_comb begin
    s_prod   = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
    u_prod   = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    div_zero = (b == '0);
    div_ovf  = (op == MD_DIV) && (a == MOST_NEG) && (b == ALL_ONES);
    divisor  = (div_zero || div_ovf) ? ONE : b;
    s_quot   = $signed(a) / $signed(divisor);
    s_rem    = $signed(a) % $signed(divisor);
    u_quot   = a / divisor;
    u_rem    = a % divisor;
  end

  always_comb begin
    result = {hi, lo};
    case (op)
      MD_MULT:  result = $unsigned(s_prod);
      MD_MULTU: result = u_prod;
      MD_MADD:  result = {hi, lo} + $unsigned(s_prod);
      MD_MADDU: result = {hi, lo} + u_prod;
      MD_DIV: begin
        if (div_zero)     result = {a, ALL_ONES};
        else if (div_ovf) result = {{WIDTH{1'b0}}, MOST_NEG};
        else              result = {s_rem, s_quot};
      end
      MD_DIVU: begin
        if (div_zero) result = {a, ALL_ONES};
        else          result = {u_rem, u_quot};
      end
      default: result = {hi, lo};
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the EX stage;
// holds the FSM, latency counter, operand latches and HI/LO.
module md_unit import md_pkg::*; #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic clk,
  input logic reset_n,
  md_if.slave bus
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  md_op_e             op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [2*WIDTH-1:0] calc_result;
  logic               busy;

  md_calc #(.WIDTH(WIDTH)) u_calc (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .hi     (hi_q),
    .lo     (lo_q),
    .result (calc_result)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= MD_MULT;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Starts are only honoured in IDLE; madd reads {hi,lo} at the completion edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (is_multi_cycle(bus.md_op)) begin
            state_d = ST_RUN;
            op_d    = bus.md_op;
            a_d     = bus.rs_data;
            b_d     = bus.rt_data;
            cnt_d   = is_div(bus.md_op) ? DIV_LOAD : MULT_LOAD;
          end else if (bus.md_op == MD_MTHI) begin
            hi_d = bus.rs_data;
          end else begin
            lo_d = bus.rs_data;
          end
        end
      end
      ST_RUN: begin
        if (cnt_q == '0) begin
          state_d      = ST_IDLE;
          {hi_d, lo_d} = calc_result;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy          = (state_q == ST_RUN);
    bus.busy      = busy;
    bus.stall_req = bus.md_type & (busy | (bus.start & is_multi_cycle(bus.md_op)));
    bus.hi        = hi_q;
    bus.lo        = lo_q;
  end

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: one instance at default latency, one at
// single-cycle latency, each with its own expected-result queue and monitor.
module tb_md_unit;
  import md_pkg::*;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t q1[$];
  exp_t q2[$];
  int   run1 = 0;
  int   run2 = 0;
  int   stall_cycles;

  md_if #(.WIDTH(32)) bus1 ();
  md_if #(.WIDTH(32)) bus2 ();

  md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut1 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus1.slave)
  );

  md_unit #(.WIDTH(32), .MULT_CYCLES(1), .DIV_CYCLES(1)) dut2 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus2.slave)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic expectOp(input int sel, input string name, input logic [31:0] hi, input logic [31:0] lo,
                          input int cycles);
    exp_t e;
    e.name   = name;
    e.hi     = hi;
    e.lo     = lo;
    e.cycles = cycles;
    if (sel == 0) q1.push_back(e);
    else          q2.push_back(e);
  endtask

  // Drives one request for a single cycle; operands are left on the bus afterwards.
  task automatic applyStimulus(input int sel, input md_op_e op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    if (sel == 0) begin
      bus1.start = 1'b1; bus1.md_op = op; bus1.rs_data = a; bus1.rt_data = b;
    end else begin
      bus2.start = 1'b1; bus2.md_op = op; bus2.rs_data = a; bus2.rt_data = b;
    end
    @(posedge clk);
    #1;
    bus1.start = 1'b0;
    bus2.start = 1'b0;
  endtask

  task automatic waitIdle();
    int i = 0;
    while (i < 200 && (q1.size() != 0 || q2.size() != 0 || bus1.busy || bus2.busy)) begin
      @(negedge clk);
      #1;
      i++;
    end
    checkOutput("scoreboard drained", 64'(q1.size() + q2.size()), 64'd0);
  endtask

  always @(negedge clk) begin : mon1
    exp_t e;
    if (!reset_n) run1 = 0;
    else if (bus1.busy) run1++;
    else if (run1 != 0) begin
      checkOutput("dut1 completion expected", 64'(q1.size() != 0), 64'd1);
      if (q1.size() != 0) begin
        e = q1.pop_front();
        checkOutput({e.name, " hi"}, 64'(bus1.hi), 64'(e.hi));
        checkOutput({e.name, " lo"}, 64'(bus1.lo), 64'(e.lo));
        checkOutput({e.name, " busy cycles"}, 64'(run1), 64'(e.cycles));
      end
      run1 = 0;
    end
  end

  always @(negedge clk) begin : mon2
    exp_t e;
    if (!reset_n) run2 = 0;
    else if (bus2.busy) run2++;
    else if (run2 != 0) begin
      checkOutput("dut2 completion expected", 64'(q2.size() != 0), 64'd1);
      if (q2.size() != 0) begin
        e = q2.pop_front();
        checkOutput({e.name, " hi"}, 64'(bus2.hi), 64'(e.hi));
        checkOutput({e.name, " lo"}, 64'(bus2.lo), 64'(e.lo));
        checkOutput({e.name, " busy cycles"}, 64'(run2), 64'(e.cycles));
      end
      run2 = 0;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus1.start = 1'b0; bus1.md_op = MD_MULT; bus1.rs_data = '0; bus1.rt_data = '0; bus1.md_type = 1'b0;
    bus2.start = 1'b0; bus2.md_op = MD_MULT; bus2.rs_data = '0; bus2.rt_data = '0; bus2.md_type = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset hi", 64'(bus1.hi), 64'd0);
    checkOutput("reset lo", 64'(bus1.lo), 64'd0);
    checkOutput("reset busy", 64'(bus1.busy), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    applyStimulus(0, MD_MTHI, 32'h12345678, 32'h0);
    checkOutput("mthi hi", 64'(bus1.hi), 64'h12345678);
    checkOutput("mthi lo unchanged", 64'(bus1.lo), 64'h0);
    checkOutput("mthi busy", 64'(bus1.busy), 64'd0);
    applyStimulus(0, MD_MTLO, 32'hCAFEBABE, 32'h0);
    checkOutput("mtlo lo", 64'(bus1.lo), 64'hCAFEBABE);
    checkOutput("mtlo hi unchanged", 64'(bus1.hi), 64'h12345678);
    checkOutput("mtlo busy", 64'(bus1.busy), 64'd0);

    expectOp(0, "mult", 32'hFFFFFFFF, 32'hFFFFFFFA, 5);
    applyStimulus(0, MD_MULT, 32'hFFFFFFFE, 32'h3);
    waitIdle();
    expectOp(0, "multu", 32'h2, 32'hFFFFFFFA, 5);
    applyStimulus(0, MD_MULTU, 32'hFFFFFFFE, 32'h3);
    waitIdle();
    expectOp(0, "div -7/2", 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    applyStimulus(0, MD_DIV, 32'hFFFFFFF9, 32'h2);
    waitIdle();
    expectOp(0, "divu by zero", 32'h7, 32'hFFFFFFFF, 10);
    applyStimulus(0, MD_DIVU, 32'h7, 32'h0);
    waitIdle();
    expectOp(0, "div overflow", 32'h0, 32'h80000000, 10);
    applyStimulus(0, MD_DIV, 32'h80000000, 32'hFFFFFFFF);
    waitIdle();

    applyStimulus(0, MD_MTHI, 32'h0, 32'h0);
    applyStimulus(0, MD_MTLO, 32'hFFFFFFFF, 32'h0);
    expectOp(0, "madd carry", 32'h1, 32'h0, 5);
    applyStimulus(0, MD_MADD, 32'h1, 32'h1);
    waitIdle();
    expectOp(0, "maddu", 32'hFFFFFFFF, 32'h1, 5);
    applyStimulus(0, MD_MADDU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    waitIdle();
    expectOp(0, "madd negative", 32'hFFFFFFFF, 32'h0, 5);
    applyStimulus(0, MD_MADD, 32'hFFFFFFFF, 32'h1);
    waitIdle();

    // mfhi sits in EX for the whole operation
    @(negedge clk);
    bus1.md_type = 1'b1;
    #1;
    checkOutput("stall idle mfhi", 64'(bus1.stall_req), 64'd0);
    expectOp(0, "mult stall", 32'h0, 32'hC, 5);
    @(negedge clk);
    bus1.start = 1'b1; bus1.md_op = MD_MULT; bus1.rs_data = 32'h3; bus1.rt_data = 32'h4;
    #1;
    checkOutput("stall on start", 64'(bus1.stall_req), 64'd1);
    @(posedge clk);
    #1;
    bus1.start = 1'b0;
    stall_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (!bus1.busy) break;
      if (bus1.stall_req) stall_cycles++;
    end
    checkOutput("stall busy cycles", 64'(stall_cycles), 64'd5);
    checkOutput("stall drop", 64'(bus1.stall_req), 64'd0);
    bus1.md_type = 1'b0;
    waitIdle();

    expectOp(0, "div ignore starts", 32'h2, 32'hE, 10);
    applyStimulus(0, MD_DIV, 32'd100, 32'd7);
    @(posedge clk);
    applyStimulus(0, MD_MULT, 32'h5, 32'h5);
    applyStimulus(0, MD_MTHI, 32'hAAAAAAAA, 32'h0);
    waitIdle();
    repeat (3) @(negedge clk);
    checkOutput("hi after ignored starts", 64'(bus1.hi), 64'h2);

    expectOp(0, "multu isolation", 32'h1, 32'h0, 5);
    applyStimulus(0, MD_MULTU, 32'h00010000, 32'h00010000);
    bus1.rs_data = 32'hDEADBEEF;
    bus1.rt_data = 32'h55555555;
    bus1.md_op   = MD_DIV;
    waitIdle();

    applyStimulus(0, MD_MTLO, 32'h0BADF00D, 32'h0);
    applyStimulus(0, MD_DIV, 32'd50, 32'd3);
    repeat (3) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("abort hi", 64'(bus1.hi), 64'd0);
    checkOutput("abort lo", 64'(bus1.lo), 64'd0);
    checkOutput("abort busy", 64'(bus1.busy), 64'd0);
    repeat (2) @(negedge clk);
    #2;
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    checkOutput("no write after abort", 64'({bus1.hi, bus1.lo}), 64'd0);
    waitIdle();

    expectOp(1, "fast mult", 32'h0, 32'd42, 1);
    applyStimulus(1, MD_MULT, 32'd6, 32'd7);
    waitIdle();
    expectOp(1, "fast div", 32'hFFFFFFFF, 32'hFFFFFFFD, 1);
    applyStimulus(1, MD_DIV, 32'hFFFFFFF9, 32'h2);
    waitIdle();
    expectOp(1, "fast divu by zero", 32'h7, 32'hFFFFFFFF, 1);
    applyStimulus(1, MD_DIVU, 32'h7, 32'h0);
    waitIdle();
    expectOp(1, "fast madd", 32'h8, 32'h0, 1);
    applyStimulus(1, MD_MADD, 32'h1, 32'h1);
    waitIdle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Parametrised multiply/divide unit with HI/LO registers for the pipelined MIPS core.
- Executes the instruction class that the decoder flags as MD-type: mult, multu, div, divu, madd, maddu, mthi and mtlo.
- Mult/div/madd ops are multi-cycle with configurable latency. The unit raises a stall request so the pipeline freezes any MD-type instruction that arrives while an operation is in flight.
- Sits in the EX stage beside the ALU. mfhi/mflo read the hi/lo outputs directly.

Parameters:
- WIDTH, 32, operand and HI/LO register width.
- MULT_CYCLES, 5, busy cycles for mult/multu/madd/maddu (legal range 1..63).
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..63).

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  EX-stage MD instruction valid this cycle (already stall-qualified by the pipeline).
- md_op  input  3  operation code, encoding from the shared package.
- rs_data  input  WIDTH  operand A (forwarded value).
- rt_data  input  WIDTH  operand B (forwarded value).
- md_type  input  1  instruction currently in EX is MD-type (including mfhi/mflo).
- busy  output  1  operation in flight.
- stall_req  output  1  freeze request to the hazard unit.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (asynchronous, active-low):
  - hi=0, lo=0, busy=0, internal state IDLE, counter=0.
  - Reset asserted mid-operation aborts the operation immediately; no HI/LO write occurs.
- States:
  - IDLE -> RUN on start with a mult/div/madd op. Operands and op are latched at that edge.
  - The counter loads the op latency minus 1.
  - RUN decrements the counter each cycle. At the edge where counter==0 and state is RUN: HI/LO are written, state returns to IDLE, busy drops.
- Latency and busy:
  - busy is 1 for exactly MULT_CYCLES or DIV_CYCLES cycles after the start edge.
  - The new HI/LO value is visible on the first cycle where busy=0.
- mthi/mtlo:
  - With start in IDLE, hi or lo takes rs_data at that edge.
  - busy never asserts. The other register is unchanged.
- Ignored starts:
  - start while busy is ignored. The hazard unit prevents this case; the bench checks that it is ignored.
  - start with md_type=1 for mfhi/mflo uses no md_op; the unit ignores it.
- Stall: stall_req = md_type & (busy | (start & op is mult/div/madd class)).
- Arithmetic:
  - mult: signed 2W-bit product. multu: unsigned 2W-bit product. {hi,lo} = product.
  - madd: {hi,lo} += signed product. maddu: {hi,lo} += unsigned product. The add is modulo 2^(2W).
  - The madd base {hi,lo} is sampled at the completion edge, not the start edge. Since no MD op can intervene, the result is the same either way.
  - div (signed, truncating toward zero): lo=quotient, hi=remainder, with the remainder taking the sign of the dividend. divu is unsigned.
- Boundary cases:
  - Divide by zero: lo = all ones, hi = dividend. This applies to both div and divu.
  - Signed overflow (most negative value / -1): lo = most negative value, hi = 0.
- Operands are never re-sampled during RUN. Changes on rs_data/rt_data after the start edge have no effect.

Decomposition:
- Shared package md_pkg holds:
  - Op encoding: MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3, MD_MADD=4, MD_MADDU=5, MD_MTHI=6, MD_MTLO=7.
  - The predicate "op is multi-cycle" (codes 0..5).
  - The FSM state typedef.
- Sub-module md_calc is combinational:
  - Inputs: latched op, operands, current {hi,lo}.
  - Output: the 2W-bit result, including the divide-by-zero and overflow rules.
  - md_unit holds the FSM, counter, latches and HI/LO.

Test Plan:
- Reset and mthi/mtlo:
  - reset_n low mid-run -> hi=lo=0 and busy=0 immediately.
  - mthi 0x12345678 -> hi=0x12345678 next cycle, busy stays 0.
- Multiply:
  - mult 0xFFFFFFFE x 0x00000003 -> after 5 busy cycles hi=0xFFFFFFFF, lo=0xFFFFFFFA.
  - multu with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- Divide:
  - div 0xFFFFFFF9 / 2 (i.e. -7/2) -> after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - divu 7 / 0 -> lo=0xFFFFFFFF, hi=0x00000007.
  - div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- madd accumulation: hi=0, lo=0xFFFFFFFF, then madd 1 x 1 -> hi=0x00000001, lo=0x00000000.
- Stall handshake:
  - mfhi presented (md_type=1) during busy -> stall_req=1 every busy cycle, dropping the cycle hi updates.
  - start asserted during busy -> ignored, result and timing unchanged.
- Operand isolation and parameters:
  - Change rs_data/rt_data during RUN -> result matches the operands at the start edge.
  - Rerun with MULT_CYCLES=1, DIV_CYCLES=1 -> busy asserts exactly one cycle.
